// File: rtl/data_mem_ctrl.sv
// rtl/data_mem_ctrl.sv - multi-cycle MEM-stage data memory with RV32 lane select and extension
module data_mem_ctrl #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 3
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        MEM_READ,
    input  logic        MEM_WRITE,
    input  logic [2:0]  FUNCT3,
    input  logic [31:0] ADDRESS,
    input  logic [31:0] WRITE_DATA,
    output logic [31:0] READ_DATA,
    output logic        BUSY
);
    localparam int         IDX_W      = $clog2(DEPTH_WORDS);
    localparam logic [3:0] COUNT_INIT = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t      state, next_state;
    logic [3:0]  count, next_count;
    logic        request, accept, complete;
    logic [31:0] req_address, req_write_data;
    logic [2:0]  req_funct3;
    logic        req_store;
    logic [31:0] op_address, op_write_data;
    logic [2:0]  op_funct3;
    logic        op_store;
    logic [31:0] mem [DEPTH_WORDS];
    logic [IDX_W-1:0] word_index;
    logic [31:0] word, load_value, store_word;
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    assign request  = MEM_READ | MEM_WRITE;
    assign complete = (next_state == DONE);

    always_comb begin
        next_state = state;
        next_count = count;
        BUSY       = 1'b0;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (request) begin
                    // gated so the stall drops the instant reset is asserted
                    BUSY       = RESET;
                    accept     = 1'b1;
                    next_state = (LATENCY == 1) ? DONE : ACCESS;
                    next_count = COUNT_INIT;
                end
            end
            ACCESS: begin
                BUSY = 1'b1;
                if (count == 4'd0) next_state = DONE;
                else               next_count = count - 4'd1;
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // With a single-cycle latency the access happens on the accepting edge,
    // so the live inputs stand in for the not-yet-latched request.
    always_comb begin
        if (state == IDLE) begin
            op_address    = ADDRESS;
            op_write_data = WRITE_DATA;
            op_funct3     = FUNCT3;
            op_store      = MEM_WRITE;
        end else begin
            op_address    = req_address;
            op_write_data = req_write_data;
            op_funct3     = req_funct3;
            op_store      = req_store;
        end
    end

    assign word_index = op_address[IDX_W+1:2];
    assign word       = mem[word_index];
    assign sel_byte   = word[{op_address[1:0], 3'b000} +: 8];
    assign sel_half   = op_address[1] ? word[31:16] : word[15:0];

    always_comb begin
        case (op_funct3)
            3'b000:  load_value = {{24{sel_byte[7]}}, sel_byte};
            3'b100:  load_value = {24'd0, sel_byte};
            3'b001:  load_value = {{16{sel_half[15]}}, sel_half};
            3'b101:  load_value = {16'd0, sel_half};
            default: load_value = word;
        endcase
    end

    always_comb begin
        store_word = word;
        case (op_funct3)
            3'b000: store_word[{op_address[1:0], 3'b000} +: 8] = op_write_data[7:0];
            3'b001: begin
                if (op_address[1]) store_word[31:16] = op_write_data[15:0];
                else               store_word[15:0]  = op_write_data[15:0];
            end
            default: store_word = op_write_data;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state          <= IDLE;
            count          <= 4'd0;
            READ_DATA      <= 32'd0;
            req_address    <= 32'd0;
            req_write_data <= 32'd0;
            req_funct3     <= 3'd0;
            req_store      <= 1'b0;
            for (int i = 0; i < DEPTH_WORDS; i++) mem[i] <= 32'd0;
        end else begin
            state <= next_state;
            count <= next_count;
            if (accept) begin
                req_address    <= ADDRESS;
                req_write_data <= WRITE_DATA;
                req_funct3     <= FUNCT3;
                req_store      <= MEM_WRITE;
            end
            if (complete) begin
                if (op_store) mem[word_index] <= store_word;
                else          READ_DATA       <= load_value;
            end
        end
    end
endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb/tb_data_mem_ctrl.sv - self-checking bench for data_mem_ctrl (LATENCY 3 and 1 builds)
module tb_data_mem_ctrl;
    logic        CLK;
    logic        rst_n;
    logic        mr [2];
    logic        mw [2];
    logic [2:0]  f3 [2];
    logic [31:0] ad [2];
    logic [31:0] wd [2];
    logic [31:0] rd_o [2];
    logic        busy_o [2];

    logic        exp_busy [2];
    logic [31:0] exp_rd [2];
    logic [7:0]  mm [2][1024];
    int          lat [2] = '{3, 1};
    logic        chk_en;
    int          pass_cnt = 0;
    int          total_cnt = 0;

    data_mem_ctrl #(.DEPTH_WORDS(256), .LATENCY(3)) u_dut3 (
        .CLK(CLK), .RESET(rst_n), .MEM_READ(mr[0]), .MEM_WRITE(mw[0]),
        .FUNCT3(f3[0]), .ADDRESS(ad[0]), .WRITE_DATA(wd[0]),
        .READ_DATA(rd_o[0]), .BUSY(busy_o[0])
    );

    data_mem_ctrl #(.DEPTH_WORDS(256), .LATENCY(1)) u_dut1 (
        .CLK(CLK), .RESET(rst_n), .MEM_READ(mr[1]), .MEM_WRITE(mw[1]),
        .FUNCT3(f3[1]), .ADDRESS(ad[1]), .WRITE_DATA(wd[1]),
        .READ_DATA(rd_o[1]), .BUSY(busy_o[1])
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Byte-addressed model: 256 words = 1024 bytes, little-endian, wraps on address[9:0]
    function automatic logic [31:0] mload(input int d, input logic [31:0] a, input logic [2:0] f);
        int b  = int'(a[9:0]);
        int hb = b & ~1;
        int wb = b & ~3;
        logic [15:0] h = {mm[d][hb+1], mm[d][hb]};
        case (f)
            3'b000:  return {{24{mm[d][b][7]}}, mm[d][b]};
            3'b100:  return {24'd0, mm[d][b]};
            3'b001:  return {{16{h[15]}}, h};
            3'b101:  return {16'd0, h};
            default: return {mm[d][wb+3], mm[d][wb+2], mm[d][wb+1], mm[d][wb]};
        endcase
    endfunction

    task automatic mstore(input int d, input logic [31:0] a, input logic [2:0] f, input logic [31:0] v);
        int b  = int'(a[9:0]);
        int hb = b & ~1;
        int wb = b & ~3;
        case (f)
            3'b000: mm[d][b] = v[7:0];
            3'b001: begin mm[d][hb] = v[7:0]; mm[d][hb+1] = v[15:8]; end
            default: begin
                mm[d][wb] = v[7:0];   mm[d][wb+1] = v[15:8];
                mm[d][wb+2] = v[23:16]; mm[d][wb+3] = v[31:24];
            end
        endcase
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 1024; i++) mm[d][i] = 8'd0;
            exp_rd[d]   = 32'd0;
            exp_busy[d] = 1'b0;
        end
    endtask

    always @(negedge CLK) begin
        if (chk_en) begin
            for (int d = 0; d < 2; d++) begin
                check(d == 0 ? "busy_lat3" : "busy_lat1", {31'd0, busy_o[d]}, {31'd0, exp_busy[d]});
                check(d == 0 ? "rdata_lat3" : "rdata_lat1", rd_o[d], exp_rd[d]);
            end
        end
    end

    // Starts at posedge+1 of an IDLE cycle; returns at posedge+1 of the following IDLE cycle.
    task automatic op(input int d, input logic r, input logic w, input logic [2:0] f,
                      input logic [31:0] a, input logic [31:0] v);
        mr[d] = r; mw[d] = w; f3[d] = f; ad[d] = a; wd[d] = v;
        exp_busy[d] = 1'b1;
        for (int k = 1; k < lat[d]; k++) begin
            @(posedge CLK); #1;
            ad[d] = $urandom; wd[d] = $urandom; f3[d] = 3'($urandom);
        end
        @(posedge CLK); #1;
        exp_busy[d] = 1'b0;
        if (w) mstore(d, a, f, v);
        else   exp_rd[d] = mload(d, a, f);
        @(posedge CLK); #1;
        mr[d] = 1'b0; mw[d] = 1'b0;
    endtask

    task automatic lit(input string name, input int d, input logic [31:0] exp);
        check(name, rd_o[d], exp);
    endtask

    initial begin
        chk_en = 1'b0;
        rst_n  = 1'b0;
        for (int d = 0; d < 2; d++) begin
            mr[d] = 1'b0; mw[d] = 1'b0; f3[d] = 3'd0; ad[d] = 32'd0; wd[d] = 32'd0;
        end
        model_reset();
        repeat (2) @(posedge CLK);
        #1;
        chk_en = 1'b1;
        check("reset_rdata", rd_o[0], 32'd0);
        check("reset_busy", {31'd0, busy_o[0]}, 32'd0);
        rst_n = 1'b1;

        op(0, 1'b0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF);
        op(0, 1'b1, 1'b0, 3'b010, 32'h10, 32'h0);         lit("lw_10", 0, 32'hDEADBEEF);
        op(0, 1'b1, 1'b0, 3'b000, 32'h13, 32'h0);         lit("lb_13", 0, 32'hFFFFFFDE);
        op(0, 1'b1, 1'b0, 3'b100, 32'h13, 32'h0);         lit("lbu_13", 0, 32'h000000DE);
        op(0, 1'b1, 1'b0, 3'b001, 32'h12, 32'h0);         lit("lh_12", 0, 32'hFFFFDEAD);
        op(0, 1'b1, 1'b0, 3'b101, 32'h10, 32'h0);         lit("lhu_10", 0, 32'h0000BEEF);
        op(0, 1'b0, 1'b1, 3'b000, 32'h11, 32'hAAAAAA55);
        op(0, 1'b1, 1'b0, 3'b010, 32'h10, 32'h0);         lit("sb_11", 0, 32'hDEAD55EF);
        op(0, 1'b0, 1'b1, 3'b001, 32'h13, 32'hFFFF1234);
        op(0, 1'b1, 1'b0, 3'b010, 32'h10, 32'h0);         lit("sh_12", 0, 32'h123455EF);

        op(0, 1'b1, 1'b1, 3'b010, 32'h30, 32'hCAFEF00D);  lit("rw_is_store", 0, 32'h123455EF);
        op(0, 1'b1, 1'b0, 3'b010, 32'h33, 32'h0);         lit("lw_unaligned", 0, 32'hCAFEF00D);
        op(0, 1'b1, 1'b0, 3'b101, 32'h33, 32'h0);         lit("lhu_33", 0, 32'h0000CAFE);
        op(0, 1'b1, 1'b0, 3'b000, 32'h30, 32'h0);         lit("lb_pos", 0, 32'h0000000D);
        op(0, 1'b1, 1'b0, 3'b011, 32'h31, 32'h0);         lit("f3_011_word", 0, 32'hCAFEF00D);

        op(0, 1'b0, 1'b1, 3'b010, 32'h400, 32'hA5A5A5A5);
        op(0, 1'b1, 1'b0, 3'b010, 32'h0, 32'h0);          lit("wrap", 0, 32'hA5A5A5A5);

        mr[0] = 1'b0; mw[0] = 1'b1; f3[0] = 3'b010; ad[0] = 32'h20; wd[0] = 32'hFFFFFFFF;
        exp_busy[0] = 1'b1;
        @(posedge CLK); #1;
        rst_n = 1'b0;
        mw[0] = 1'b0;
        model_reset();
        #1;
        check("abort_busy", {31'd0, busy_o[0]}, 32'd0);
        check("abort_rdata", rd_o[0], 32'd0);
        @(posedge CLK); #1;
        rst_n = 1'b1;
        op(0, 1'b1, 1'b0, 3'b010, 32'h20, 32'h0);         lit("abort_no_write", 0, 32'h0);

        op(1, 1'b0, 1'b1, 3'b010, 32'h40, 32'h0BADF00D);
        op(1, 1'b1, 1'b0, 3'b010, 32'h40, 32'h0);         lit("l1_lw", 1, 32'h0BADF00D);
        op(1, 1'b1, 1'b0, 3'b001, 32'h42, 32'h0);         lit("l1_lh", 1, 32'h00000BAD);
        for (int i = 0; i < 8; i++) begin
            op(1, 1'b0, 1'b1, 3'(i % 3), 32'h100 + 32'(4 * i) + 32'(i % 4), $urandom);
            op(1, 1'b1, 1'b0, 3'b010, 32'h100 + 32'(4 * i), 32'h0);
        end

        @(posedge CLK); #1;
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/data_mem_ctrl.md
Name: data_mem_ctrl

Overview:
- Memory-stage data memory responder. Serves the load/store requests issued by the MEM stage and produces the read data that the MEM/WB pipeline register captures.
- Models a fixed multi-cycle backing memory. Asserts BUSY to stall the pipeline until each access completes.
- Performs RV32 byte, half and word lane selection, with sign or zero extension on loads.

Parameters:
- DEPTH_WORDS, 256, number of 32-bit words in the internal array; word index = ADDRESS[31:2] modulo DEPTH_WORDS (power of 2).
- LATENCY, 3, cycles from request acceptance to completion (legal range 1..15).

Ports:
- CLK  input  1  clock; all state updates on posedge.
- RESET  input  1  asynchronous, active-low reset.
- MEM_READ  input  1  load request from the MEM stage.
- MEM_WRITE  input  1  store request from the MEM stage.
- FUNCT3  input  3  access size and extension (RV32 load/store funct3).
- ADDRESS  input  32  byte address (MEM_ALU_OUT).
- WRITE_DATA  input  32  store data; bytes taken from the low lanes.
- READ_DATA  output  32  extended load result; registered.
- BUSY  output  1  pipeline stall request; combinational.

Behaviour:
- Reset (RESET=0, asynchronous):
  - state IDLE, counter 0, READ_DATA 0, BUSY 0.
  - All array words cleared to 0.
  - Reset asserted mid-access aborts the access: no write occurs and READ_DATA stays 0.
- FSM states:
  - IDLE: if MEM_READ|MEM_WRITE, latch ADDRESS, FUNCT3, WRITE_DATA and the op, then go to DONE if LATENCY=1, else go to ACCESS with counter=LATENCY-2. With no request, stay in IDLE.
  - ACCESS: if counter=0 go to DONE, else decrement the counter.
  - DONE: always return to IDLE next edge. MEM_READ/MEM_WRITE sampled in DONE belong to the completed instruction and are ignored.
- BUSY = (IDLE and (MEM_READ|MEM_WRITE)) or ACCESS.
  - BUSY is high for exactly LATENCY cycles, starting in the request cycle.
  - BUSY is low in DONE. The pipeline advances on the DONE edge.
- The access is performed on the edge that enters DONE, using the latched request.
  - Load: READ_DATA updated; valid throughout the DONE cycle; held until the next load completes.
  - Store: array written; READ_DATA unchanged.
- Lane and extension rules:
  - FUNCT3 000: byte ADDRESS[1:0]; load sign-extended; store writes that byte only.
  - FUNCT3 001: half ADDRESS[1]; load sign-extended; store writes that half only. ADDRESS[0] ignored.
  - FUNCT3 010: word; ADDRESS[1:0] ignored.
  - FUNCT3 100: byte, zero-extended (load only).
  - FUNCT3 101: half, zero-extended (load only).
  - Other FUNCT3 values: treated as 010.
- MEM_READ and MEM_WRITE both high: treated as a store; READ_DATA unchanged.
- Addresses beyond the array wrap modulo DEPTH_WORDS; no error signalled.
- Back-to-back requests: a new request seen in IDLE on the cycle after DONE is accepted immediately. The minimum request spacing is LATENCY+1 cycles.
- Inputs that change during ACCESS have no effect; only the latched values are used.

Test Plan:
- Reset, then SW 0xDEADBEEF to addr 0x10 → BUSY high cycles 0-2, low cycle 3. Then LW 0x10 → READ_DATA=0xDEADBEEF in its DONE cycle.
- From the same word: LB 0x13 → 0xFFFFFFDE; LBU 0x13 → 0x000000DE; LH 0x12 → 0xFFFFDEAD; LHU 0x10 → 0x0000BEEF.
- SB 0x55 to 0x11 over word 0x10 = 0xDEADBEEF → LW 0x10 returns 0xDEAD55EF. SH 0x1234 to 0x12 → LW returns 0x123455EF.
- Wrap: SW 0xA5A5A5A5 to 0x400 (DEPTH_WORDS=256) → LW 0x0 returns 0xA5A5A5A5.
- Reset pulsed during ACCESS of SW 0xFFFFFFFF to 0x20 → BUSY drops immediately, state IDLE, READ_DATA=0. Subsequent LW 0x20 returns 0.
- LATENCY=1 build: LW request → BUSY high for 1 cycle only, DONE next cycle. Continuous back-to-back LW/SW alternation has no lost or duplicated accesses.
